// File: rtl/asic_sprite_mixer.sv
// asic_sprite_mixer
// -----------------
// Compositing stage of the Plus ASIC video path. Each clock it takes the
// sprite unit's result for one pixel (active flag, sprite id, pattern pen)
// and the background pixel. It resolves the sprite pen through a 15-entry
// 12-bit palette and muxes the result over the background. It also latches
// sticky sprite-vs-background collisions per sprite.
//
// Pixel latency from inputs to rgb_out/sprite_vis is fixed at 2 clocks.
// Throughput is one pixel per clock.
//
// CPU map (plus_mode = 1):
//   PAL_BASE + 2(n-1)      pen n low byte  {R[3:0], B[3:0]}
//   PAL_BASE + 2(n-1) + 1  pen n high byte {4'b0,   G[3:0]}
//   COLL_BASE              collision flags[7:0]  (read clears this byte)
//   COLL_BASE + 1          collision flags[15:8] (read clears this byte)
//   any write to COLL_BASE/COLL_BASE+1 clears all 16 flags
// With plus_mode = 0, writes are ignored and mapped reads return 8'hFF.
// Unmapped addresses never respond.
//
// Ports:
//   clk_sys, reset              clock, synchronous active-high reset
//   plus_mode                   Plus features enable (0 = passthrough)
//   cpu_addr/cpu_data           CPU address / write data
//   cpu_wr/cpu_rd               one-cycle access strobes (write wins)
//   cpu_dout/cpu_dout_valid     read data, valid one cycle after the read
//   hblank/vblank               blanking inputs
//   sprite_active/id/pix        sprite unit result for this pixel
//   bg_rgb/bg_ink               background colour and ink flag
//   rgb_out/sprite_vis          composited pixel and sprite-source flag
//   collision_flags             sticky per-sprite collision bits
module asic_sprite_mixer #(
    parameter logic [15:0] PAL_BASE  = 16'h6422,
    parameter logic [15:0] COLL_BASE = 16'h6440
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        plus_mode,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    output logic        cpu_dout_valid,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        sprite_active,
    input  logic [3:0]  sprite_id,
    input  logic [3:0]  sprite_pix,
    input  logic [11:0] bg_rgb,
    input  logic        bg_ink,
    output logic [11:0] rgb_out,
    output logic        sprite_vis,
    output logic [15:0] collision_flags
);

    localparam int unsigned PAL_ENTRIES = 32'd15;

    // CPU decode
    logic [15:0] pal_off_s;
    logic [15:0] coll_off_s;
    logic        pal_hit_s;
    logic        coll_hit_s;
    logic [3:0]  pal_idx_s;
    logic        pal_hi_s;
    logic        rd_acc_s;
    logic        pal_we_s;
    logic        coll_we_s;
    logic        coll_rd_s;
    logic [7:0]  rd_data_s;

    // Palette, entry i holds pen i+1 as {R,G,B}
    logic [11:0] pal_r [PAL_ENTRIES];

    // Stage 1 pixel registers
    logic        blank_s1_r;
    logic        opaque_s1_r;
    logic [3:0]  id_s1_r;
    logic [3:0]  pix_s1_r;
    logic [11:0] bg_s1_r;
    logic        ink_s1_r;

    // Stage 2 next-state and registers
    logic [11:0] pen_rgb_s;
    logic [11:0] rgb_next_s;
    logic        vis_next_s;
    logic [15:0] coll_set_s;
    logic [15:0] coll_clr_s;
    logic [11:0] rgb_out_r;
    logic        sprite_vis_r;
    logic [15:0] flags_r;
    logic [7:0]  cpu_dout_r;
    logic        cpu_dout_valid_r;

    // Address decode and access qualification; a write masks a same-cycle read
    always_comb begin
        pal_off_s  = cpu_addr - PAL_BASE;
        coll_off_s = cpu_addr - COLL_BASE;
        pal_hit_s  = (pal_off_s < 16'd30);
        coll_hit_s = (coll_off_s < 16'd2);
        pal_idx_s  = pal_off_s[4:1];
        pal_hi_s   = pal_off_s[0];
        rd_acc_s   = cpu_rd & ~cpu_wr & (pal_hit_s | coll_hit_s);
        pal_we_s   = cpu_wr & plus_mode & pal_hit_s;
        coll_we_s  = cpu_wr & plus_mode & coll_hit_s;
        coll_rd_s  = rd_acc_s & plus_mode & coll_hit_s;
    end

    // Read data selection for mapped addresses
    always_comb begin
        rd_data_s = 8'h00;
        if (!plus_mode) begin
            rd_data_s = 8'hFF;
        end else if (coll_hit_s) begin
            rd_data_s = coll_off_s[0] ? flags_r[15:8] : flags_r[7:0];
        end else if (pal_hit_s) begin
            if (pal_hi_s) begin
                rd_data_s = {4'h0, pal_r[pal_idx_s][7:4]};
            end else begin
                rd_data_s = {pal_r[pal_idx_s][11:8], pal_r[pal_idx_s][3:0]};
            end
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Stage 2 colour mux and collision set/clear masks
    always_comb begin
        if (pix_s1_r == 4'd0) begin
            pen_rgb_s = 12'h000;
        end else begin
            pen_rgb_s = pal_r[pix_s1_r - 4'd1];
        end

        if (blank_s1_r) begin
            rgb_next_s = 12'h000;
            vis_next_s = 1'b0;
        end else if (opaque_s1_r) begin
            rgb_next_s = pen_rgb_s;
            vis_next_s = 1'b1;
        end else begin
            rgb_next_s = bg_s1_r;
            vis_next_s = 1'b0;
        end

        if (!blank_s1_r && opaque_s1_r && ink_s1_r) begin
            coll_set_s = 16'd1 << id_s1_r;
        end else begin
            coll_set_s = 16'h0000;
        end

        if (coll_we_s) begin
            coll_clr_s = 16'hFFFF;
        end else if (coll_rd_s) begin
            coll_clr_s = coll_off_s[0] ? 16'hFF00 : 16'h00FF;
        end else begin
            coll_clr_s = 16'h0000;
        end
    end

    // Palette storage: each byte written independently. The lookup above reads
    // the pre-write value, so a new colour shows from the next pixel on.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int unsigned i = 32'd0; i < PAL_ENTRIES; i++) begin
                pal_r[i] <= 12'h000;
            end
        end else begin
            for (int unsigned i = 32'd0; i < PAL_ENTRIES; i++) begin
                if (pal_we_s && (pal_idx_s == 4'(i))) begin
                    if (pal_hi_s) begin
                        pal_r[i][7:4] <= cpu_data[3:0];
                    end else begin
                        pal_r[i][11:8] <= cpu_data[7:4];
                        pal_r[i][3:0]  <= cpu_data[3:0];
                    end
                end
            end
        end
    end

    // Stage 1 pixel capture; plus_mode is folded into opaque here
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            blank_s1_r  <= 1'b0;
            opaque_s1_r <= 1'b0;
            id_s1_r     <= 4'd0;
            pix_s1_r    <= 4'd0;
            bg_s1_r     <= 12'h000;
            ink_s1_r    <= 1'b0;
        end else begin
            blank_s1_r  <= hblank | vblank;
            opaque_s1_r <= plus_mode & sprite_active & (sprite_pix != 4'd0);
            id_s1_r     <= sprite_id;
            pix_s1_r    <= sprite_pix;
            bg_s1_r     <= bg_rgb;
            ink_s1_r    <= bg_ink;
        end
    end

    // Stage 2 output registers and sticky collision flags (set beats clear)
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgb_out_r    <= 12'h000;
            sprite_vis_r <= 1'b0;
            flags_r      <= 16'h0000;
        end else begin
            rgb_out_r    <= rgb_next_s;
            sprite_vis_r <= vis_next_s;
            flags_r      <= (flags_r & ~coll_clr_s) | coll_set_s;
        end
    end

    // CPU read response, one cycle after an accepted read; data holds between reads
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_dout_r       <= 8'h00;
            cpu_dout_valid_r <= 1'b0;
        end else begin
            cpu_dout_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                cpu_dout_r <= rd_data_s;
            end
        end
    end

    assign rgb_out         = rgb_out_r;
    assign sprite_vis      = sprite_vis_r;
    assign collision_flags = flags_r;
    assign cpu_dout        = cpu_dout_r;
    assign cpu_dout_valid  = cpu_dout_valid_r;

endmodule

// File: tb/tb_asic_sprite_mixer.sv
// Directed testbench for asic_sprite_mixer. Inputs change 1 time unit after
// the rising edge and outputs are sampled at that same point.
module tb_asic_sprite_mixer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        plus_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_dout;
    logic        cpu_dout_valid;
    logic        hblank;
    logic        vblank;
    logic        sprite_active;
    logic [3:0]  sprite_id;
    logic [3:0]  sprite_pix;
    logic [11:0] bg_rgb;
    logic        bg_ink;
    logic [11:0] rgb_out;
    logic        sprite_vis;
    logic [15:0] collision_flags;

    int total = 0;
    int bad   = 0;

    asic_sprite_mixer dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .plus_mode       (plus_mode),
        .cpu_addr        (cpu_addr),
        .cpu_data        (cpu_data),
        .cpu_wr          (cpu_wr),
        .cpu_rd          (cpu_rd),
        .cpu_dout        (cpu_dout),
        .cpu_dout_valid  (cpu_dout_valid),
        .hblank          (hblank),
        .vblank          (vblank),
        .sprite_active   (sprite_active),
        .sprite_id       (sprite_id),
        .sprite_pix      (sprite_pix),
        .bg_rgb          (bg_rgb),
        .bg_ink          (bg_ink),
        .rgb_out         (rgb_out),
        .sprite_vis      (sprite_vis),
        .collision_flags (collision_flags)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_wr   = 1'b1;
        tick();
        cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        tick();
        cpu_rd   = 1'b0;
        check_eq({tag, "_vld"}, 32'(cpu_dout_valid), 32'd1);
        check_eq({tag, "_dat"}, 32'(cpu_dout), 32'(exp));
    endtask

    task automatic cpu_read_none(input string tag, input logic [15:0] a);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        tick();
        cpu_rd   = 1'b0;
        check_eq(tag, 32'(cpu_dout_valid), 32'd0);
    endtask

    task automatic drive_pix(input logic act, input logic [3:0] id, input logic [3:0] pix,
                             input logic [11:0] bg, input logic ink);
        sprite_active = act;
        sprite_id     = id;
        sprite_pix    = pix;
        bg_rgb        = bg;
        bg_ink        = ink;
    endtask

    initial begin
        reset = 1'b1; plus_mode = 1'b1;
        cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
        hblank = 1'b0; vblank = 1'b0;
        drive_pix(1'b0, 4'd0, 4'd0, 12'h000, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_rgb",   32'(rgb_out), 32'h0);
        check_eq("rst_vis",   32'(sprite_vis), 32'h0);
        check_eq("rst_dout",  32'(cpu_dout), 32'h0);
        check_eq("rst_vld",   32'(cpu_dout_valid), 32'h0);
        check_eq("rst_flags", 32'(collision_flags), 32'h0);

        // Pen 1 = FA0, sprite shown exactly two cycles later
        cpu_write(16'h6422, 8'hF0);
        cpu_write(16'h6423, 8'h0A);
        drive_pix(1'b1, 4'd3, 4'd1, 12'h456, 1'b0);
        tick();
        check_eq("lat1_vis", 32'(sprite_vis), 32'h0);
        check_eq("lat1_rgb", 32'(rgb_out), 32'h0);
        tick();
        check_eq("pen1_rgb", 32'(rgb_out), 32'hFA0);
        check_eq("pen1_vis", 32'(sprite_vis), 32'h1);

        // Transparent pen shows background; hblank forces black
        drive_pix(1'b1, 4'd3, 4'd0, 12'h123, 1'b0);
        tick(); tick();
        check_eq("transp_rgb", 32'(rgb_out), 32'h123);
        check_eq("transp_vis", 32'(sprite_vis), 32'h0);
        hblank = 1'b1;
        tick();
        check_eq("hb_lat1_rgb", 32'(rgb_out), 32'h123);
        tick();
        check_eq("hb_rgb", 32'(rgb_out), 32'h000);
        hblank = 1'b0;
        drive_pix(1'b0, 4'd0, 4'd0, 12'h000, 1'b0);
        tick(); tick();

        // Collisions on sprite 0 and 9; byte-wise read clear
        drive_pix(1'b1, 4'd0, 4'd1, 12'h000, 1'b1);
        tick();
        drive_pix(1'b1, 4'd9, 4'd1, 12'h000, 1'b1);
        tick();
        drive_pix(1'b0, 4'd0, 4'd0, 12'h000, 1'b0);
        tick(); tick();
        check_eq("coll_0201", 32'(collision_flags), 32'h0201);
        cpu_read_check("rd_coll_lo", 16'h6440, 8'h01);
        check_eq("clr_lo_only", 32'(collision_flags), 32'h0200);
        tick();
        check_eq("vld_pulse", 32'(cpu_dout_valid), 32'h0);
        cpu_read_check("rd_coll_hi", 16'h6441, 8'h02);
        check_eq("clr_hi", 32'(collision_flags), 32'h0000);

        // Collision landing in the read-clear cycle: set wins
        drive_pix(1'b1, 4'd9, 4'd1, 12'h000, 1'b1);
        tick();
        drive_pix(1'b0, 4'd0, 4'd0, 12'h000, 1'b0);
        cpu_read_check("rd_race", 16'h6441, 8'h00);
        check_eq("set_wins", 32'(collision_flags), 32'h0200);
        cpu_read_check("rd_race2", 16'h6441, 8'h02);
        check_eq("race_clr", 32'(collision_flags), 32'h0000);

        // Any collision write clears everything
        drive_pix(1'b1, 4'd4, 4'd1, 12'h000, 1'b1);
        tick();
        drive_pix(1'b0, 4'd0, 4'd0, 12'h000, 1'b0);
        tick();
        check_eq("coll_0010", 32'(collision_flags), 32'h0010);
        cpu_write(16'h6441, 8'h00);
        check_eq("wr_clr", 32'(collision_flags), 32'h0000);

        // Pen 15 update while displayed: old colour first, new after
        cpu_write(16'h643E, 8'h12);
        cpu_write(16'h643F, 8'h03);
        drive_pix(1'b1, 4'd1, 4'd15, 12'h000, 1'b0);
        tick(); tick();
        check_eq("pen15_old", 32'(rgb_out), 32'h132);
        cpu_write(16'h643E, 8'h5C);
        check_eq("pen15_same_cyc", 32'(rgb_out), 32'h132);
        tick();
        check_eq("pen15_new", 32'(rgb_out), 32'h53C);
        drive_pix(1'b0, 4'd0, 4'd0, 12'h000, 1'b0);
        cpu_read_check("rd_pen15_hi", 16'h643F, 8'h03);
        cpu_read_check("rd_pen15_lo", 16'h643E, 8'h5C);

        // Unmapped addresses: no response, no write
        cpu_read_none("oor_6421", 16'h6421);
        cpu_read_none("oor_6442", 16'h6442);
        cpu_write(16'h6421, 8'hFF);
        cpu_read_check("pen1_kept", 16'h6422, 8'hF0);

        // Write and read together: write happens, read dropped
        cpu_addr = 16'h6424; cpu_data = 8'h77; cpu_wr = 1'b1; cpu_rd = 1'b1;
        tick();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        check_eq("wr_rd_novld", 32'(cpu_dout_valid), 32'h0);
        cpu_read_check("wr_rd_data", 16'h6424, 8'h77);

        // Passthrough mode
        plus_mode = 1'b0;
        cpu_write(16'h6422, 8'h11);
        cpu_read_check("np_rd_ff", 16'h6422, 8'hFF);
        drive_pix(1'b1, 4'd5, 4'd1, 12'hABC, 1'b1);
        tick(); tick();
        check_eq("np_rgb", 32'(rgb_out), 32'hABC);
        check_eq("np_vis", 32'(sprite_vis), 32'h0);
        tick();
        check_eq("np_nocoll", 32'(collision_flags), 32'h0);
        drive_pix(1'b0, 4'd0, 4'd0, 12'h000, 1'b0);
        plus_mode = 1'b1;
        tick(); tick();
        cpu_read_check("np_pal_kept", 16'h6422, 8'hF0);

        // Fill all flags, then reset mid-line
        for (int i = 0; i < 16; i++) begin
            drive_pix(1'b1, 4'(i), 4'd1, 12'h000, 1'b1);
            tick();
        end
        drive_pix(1'b0, 4'd0, 4'd0, 12'hDEF, 1'b0);
        tick(); tick();
        check_eq("flags_ffff", 32'(collision_flags), 32'hFFFF);
        check_eq("pre_rst_rgb", 32'(rgb_out), 32'hDEF);
        cpu_read_check("pre_rst_rd", 16'h6422, 8'hF0);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_rgb",   32'(rgb_out), 32'h0);
        check_eq("mid_rst_vis",   32'(sprite_vis), 32'h0);
        check_eq("mid_rst_dout",  32'(cpu_dout), 32'h0);
        check_eq("mid_rst_vld",   32'(cpu_dout_valid), 32'h0);
        check_eq("mid_rst_flags", 32'(collision_flags), 32'h0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_lat1", 32'(rgb_out), 32'h000);
        tick();
        check_eq("post_rst_pix", 32'(rgb_out), 32'hDEF);
        cpu_read_check("post_rst_pal", 16'h6422, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
